// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule constants, FSM encoding and byte/word helpers
// for the key memories.
package aes_key_pkg;

   localparam logic [3:0] AES_128_NUM_ROUNDS = 4'ha;
   localparam logic [7:0] RCON_INIT          = 8'h8d;
   localparam logic [7:0] RCON_LAST          = 8'h36;
   localparam logic [7:0] POLY               = 8'h1b;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_EMIT   = 2'd2
   } key_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (POLY & {8{b[7]}});
   endfunction

   // Undo xtime: a set LSB means the reduction polynomial was folded in.
   function automatic logic [7:0] inv_xtime(input logic [7:0] b);
      return b[0] ? (((b ^ POLY) >> 1) | 8'h80) : (b >> 1);
   endfunction

   function automatic logic [31:0] rotword(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES S-box over 16 bytes: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox
   import aes_key_pkg::*;
(
   input  logic [127:0] sboxw,
   output logic [127:0] new_sboxw
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = 8'h00;
      aa  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ aa;
         aa = xtime(aa);
      end
      return acc;
   endfunction

   // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = x;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] sub_byte(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
             {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   always_comb begin
      new_sboxw = '0;
      for (int i = 0; i < 16; i++) begin
         new_sboxw[8*i +: 8] = sub_byte(sboxw[8*i +: 8]);
      end
   end

endmodule

// File: rtl/aes_inv_key_mem.sv
// Decryption-side AES-128 key memory: expands forward to round 10, then streams
// round keys 10..0 through the inverse schedule, caching the round-10 key.
module aes_inv_key_mem
   import aes_key_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic [127:0] key,
   input  logic         init,
   input  logic         restart,
   output logic [3:0]   round,
   output logic [127:0] roundkey,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         ready,
   output logic         cached
);

   key_state_e   state, state_n;
   logic [127:0] key_reg, key_n;
   logic [127:0] last_key, last_key_n;
   logic [3:0]   round_reg, round_n;
   logic [7:0]   rc_reg, rc_n;
   logic         cached_reg, cached_n;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  sbox_word, sub_rot, t, p0;
   logic [127:0] sbox_in, sbox_out, fwd_key, inv_key;
   logic [95:0]  sbox_hi_unused;

   assign {w0, w1, w2, w3} = key_reg;

   // One S-box serves both directions: forward needs w3, inverse needs the
   // recovered previous w3, which is w3^w2.
   assign sbox_in = {96'h0, (state == ST_EXPAND) ? w3 : (w3 ^ w2)};

   aes_sbox u_sbox (
      .sboxw     (sbox_in),
      .new_sboxw (sbox_out)
   );

   assign sbox_word      = sbox_out[31:0];
   assign sbox_hi_unused = sbox_out[127:32];
   assign sub_rot        = rotword(sbox_word);

   assign t       = sub_rot ^ {xtime(rc_reg), 24'h0};
   assign fwd_key = {w0 ^ t, w1 ^ w0 ^ t, w2 ^ w1 ^ w0 ^ t, w3 ^ w2 ^ w1 ^ w0 ^ t};

   assign p0      = w0 ^ sub_rot ^ {rc_reg, 24'h0};
   assign inv_key = {p0, w1 ^ w0, w2 ^ w1, w3 ^ w2};

   always_comb begin
      state_n    = state;
      key_n      = key_reg;
      last_key_n = last_key;
      round_n    = round_reg;
      rc_n       = rc_reg;
      cached_n   = cached_reg;
      case (state)
         ST_IDLE: begin
            if (init) begin
               key_n   = key;
               round_n = 4'd0;
               rc_n    = RCON_INIT;
               state_n = ST_EXPAND;
            end else if (restart && cached_reg) begin
               key_n   = last_key;
               round_n = AES_128_NUM_ROUNDS;
               rc_n    = RCON_LAST;
               state_n = ST_EMIT;
            end
         end
         ST_EXPAND: begin
            key_n   = fwd_key;
            round_n = round_reg + 4'd1;
            rc_n    = xtime(rc_reg);
            if (round_reg == AES_128_NUM_ROUNDS - 4'd1) begin
               last_key_n = fwd_key;
               cached_n   = 1'b1;
               state_n    = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (rk_ready) begin
               if (round_reg != 4'd0) begin
                  key_n   = inv_key;
                  round_n = round_reg - 4'd1;
                  rc_n    = inv_xtime(rc_reg);
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         key_reg    <= '0;
         last_key   <= '0;
         round_reg  <= '0;
         rc_reg     <= '0;
         cached_reg <= 1'b0;
      end else begin
         state      <= state_n;
         key_reg    <= key_n;
         last_key   <= last_key_n;
         round_reg  <= round_n;
         rc_reg     <= rc_n;
         cached_reg <= cached_n;
      end
   end

   assign round    = round_reg;
   assign roundkey = key_reg;
   assign rk_valid = (state == ST_EMIT);
   assign ready    = (state == ST_IDLE);
   assign cached   = cached_reg;

endmodule

// File: tb/tb_aes_inv_key_mem.sv
// Bench for aes_inv_key_mem against a textbook AES-128 key expansion model.
module tb_aes_inv_key_mem;

   logic         clk;
   logic         reset_n;
   logic [127:0] key;
   logic         init;
   logic         restart;
   logic [3:0]   round;
   logic [127:0] roundkey;
   logic         rk_valid;
   logic         rk_ready;
   logic         ready;
   logic         cached;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]   sbox_tab [256];
   logic [127:0] exp_rk [11];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   aes_inv_key_mem dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .key      (key),
      .init     (init),
      .restart  (restart),
      .round    (round),
      .roundkey (roundkey),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .ready    (ready),
      .cached   (cached)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // S-box table built by walking generator 3 and its inverse in parallel.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      for (int n = 0; n < 255; n++) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_tab[p] = x ^ 8'h63;
      end
      sbox_tab[0] = 8'h63;
   endtask

   task automatic model_expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
            tmp = tmp ^ {rc, 24'h0};
            rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Present a start request for one cycle, then count edges until rk_valid.
   task automatic start_and_wait(input logic [127:0] k, input logic do_init,
                                 input logic do_restart, output int cyc);
      key     = k;
      init    = do_init;
      restart = do_restart;
      @(negedge clk);
      init    = 1'b0;
      restart = 1'b0;
      cyc     = 1;
      while (!rk_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      key      = '0;
      init     = 1'b0;
      restart  = 1'b0;
      rk_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (round !== 4'd0 || roundkey !== 128'h0 || rk_valid !== 1'b0 || ready !== 1'b1 || cached !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: round=%0d key=%h valid=%b ready=%b cached=%b, expected 0/0/0/1/0",
                  round, roundkey, rk_valid, ready, cached);
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (ready !== 1'b1 || rk_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b valid=%b, expected 1/0", ready, rk_valid);
      end
   endtask

   task automatic test_fips();
      int cyc;
      model_expand(FIPS_KEY);
      rk_ready = 1'b1;
      start_and_wait(FIPS_KEY, 1'b1, 1'b0, cyc);
      n_tests++;
      if (cyc != 11) begin
         n_fail++;
         $display("FAIL fips_latency: got %0d cycles, expected 11", cyc);
      end
      for (int e = 10; e >= 0; e--) begin
         n_tests++;
         if (rk_valid !== 1'b1 || round !== e[3:0] || roundkey !== exp_rk[e] ||
             (e == 10 && roundkey !== FIPS_R10) || (e == 9 && roundkey !== FIPS_R9) ||
             (e == 0 && roundkey !== FIPS_KEY)) begin
            n_fail++;
            $display("FAIL fips_r%0d: valid=%b round=%0d key=%h, expected 1/%0d/%h",
                     e, rk_valid, round, roundkey, e, exp_rk[e]);
         end
         @(negedge clk);
      end
      n_tests++;
      if (rk_valid !== 1'b0 || ready !== 1'b1 || cached !== 1'b1) begin
         n_fail++;
         $display("FAIL fips_done: valid=%b ready=%b cached=%b, expected 0/1/1", rk_valid, ready, cached);
      end
   endtask

   task automatic test_restart();
      int cyc;
      rk_ready = 1'b1;
      start_and_wait(128'h0, 1'b0, 1'b1, cyc);
      n_tests++;
      if (cyc != 1) begin
         n_fail++;
         $display("FAIL restart_latency: got %0d cycles, expected 1", cyc);
      end
      for (int e = 10; e >= 0; e--) begin
         n_tests++;
         if (rk_valid !== 1'b1 || round !== e[3:0] || roundkey !== exp_rk[e]) begin
            n_fail++;
            $display("FAIL restart_r%0d: valid=%b round=%0d key=%h, expected 1/%0d/%h",
                     e, rk_valid, round, roundkey, e, exp_rk[e]);
         end
         @(negedge clk);
      end
      n_tests++;
      if (ready !== 1'b1 || rk_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_done: ready=%b valid=%b, expected 1/0", ready, rk_valid);
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      logic [127:0] k;
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      model_expand(k);
      rk_ready = 1'b1;
      start_and_wait(k, 1'b1, 1'b0, cyc);
      n_tests++;
      if (cyc != 11) begin
         n_fail++;
         $display("FAIL bp_latency: got %0d cycles, expected 11", cyc);
      end
      for (int e = 10; e >= 0; e--) begin
         n_tests++;
         if (rk_valid !== 1'b1 || round !== e[3:0] || roundkey !== exp_rk[e]) begin
            n_fail++;
            $display("FAIL bp_r%0d: valid=%b round=%0d key=%h, expected 1/%0d/%h",
                     e, rk_valid, round, roundkey, e, exp_rk[e]);
         end
         if (e == 9) begin
            rk_ready = 1'b0;
            for (int h = 0; h < 5; h++) begin
               @(negedge clk);
               n_tests++;
               if (rk_valid !== 1'b1 || round !== 4'd9 || roundkey !== exp_rk[9]) begin
                  n_fail++;
                  $display("FAIL bp_hold%0d: valid=%b round=%0d key=%h, expected 1/9/%h",
                           h, rk_valid, round, roundkey, exp_rk[9]);
               end
            end
            rk_ready = 1'b1;
         end
         @(negedge clk);
      end
      n_tests++;
      if (ready !== 1'b1 || rk_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_done: ready=%b valid=%b, expected 1/0", ready, rk_valid);
      end
   endtask

   task automatic test_random_ready();
      int cyc;
      int e;
      int guard;
      logic r;
      logic [127:0] k;
      for (int run = 0; run < 3; run++) begin
         k = {$urandom(), $urandom(), $urandom(), $urandom()};
         model_expand(k);
         start_and_wait(k, 1'b1, 1'b0, cyc);
         n_tests++;
         if (cyc != 11) begin
            n_fail++;
            $display("FAIL rnd%0d_latency: got %0d cycles, expected 11", run, cyc);
         end
         e = 10;
         guard = 0;
         while (e >= 0 && guard < 300) begin
            n_tests++;
            if (rk_valid !== 1'b1 || round !== e[3:0] || roundkey !== exp_rk[e]) begin
               n_fail++;
               $display("FAIL rnd%0d_r%0d: valid=%b round=%0d key=%h, expected 1/%0d/%h",
                        run, e, rk_valid, round, roundkey, e, exp_rk[e]);
            end
            r = 1'($urandom_range(0, 1));
            rk_ready = r;
            @(negedge clk);
            if (r) e--;
            guard++;
         end
         n_tests++;
         if (e >= 0 || ready !== 1'b1 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd%0d_done: remaining=%0d ready=%b valid=%b, expected -1/1/0",
                     run, e, ready, rk_valid);
         end
      end
      rk_ready = 1'b1;
   endtask

   task automatic test_init_during_emit();
      int cyc;
      logic [127:0] k;
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      model_expand(k);
      rk_ready = 1'b1;
      start_and_wait(k, 1'b1, 1'b0, cyc);
      for (int e = 10; e >= 0; e--) begin
         n_tests++;
         if (rk_valid !== 1'b1 || round !== e[3:0] || roundkey !== exp_rk[e]) begin
            n_fail++;
            $display("FAIL emit_init_r%0d: valid=%b round=%0d key=%h, expected 1/%0d/%h",
                     e, rk_valid, round, roundkey, e, exp_rk[e]);
         end
         init = (e == 6);
         key  = ~k;
         @(negedge clk);
      end
      init = 1'b0;
      n_tests++;
      if (ready !== 1'b1 || rk_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL emit_init_done: ready=%b valid=%b, expected 1/0", ready, rk_valid);
      end
      start_and_wait(128'h0, 1'b0, 1'b1, cyc);
      n_tests++;
      if (cyc != 1 || round !== 4'd10 || roundkey !== exp_rk[10]) begin
         n_fail++;
         $display("FAIL emit_init_cache: cycles=%0d round=%0d key=%h, expected 1/10/%h",
                  cyc, round, roundkey, exp_rk[10]);
      end
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset_mid_expand();
      int cyc;
      key  = {$urandom(), $urandom(), $urandom(), $urandom()};
      init = 1'b1;
      @(negedge clk);
      init = 1'b0;
      repeat (5) @(negedge clk);
      n_tests++;
      if (round !== 4'd5 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_expand_round: round=%0d ready=%b, expected 5/0", round, ready);
      end
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (round !== 4'd0 || roundkey !== 128'h0 || rk_valid !== 1'b0 || ready !== 1'b1 || cached !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_expand_reset: round=%0d key=%h valid=%b ready=%b cached=%b, expected 0/0/0/1/0",
                  round, roundkey, rk_valid, ready, cached);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      restart = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++;
         if (ready !== 1'b1 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_uncached%0d: ready=%b valid=%b, expected 1/0", i, ready, rk_valid);
         end
      end
      restart = 1'b0;
      model_expand(128'h0);
      rk_ready = 1'b1;
      start_and_wait(128'h0, 1'b1, 1'b1, cyc);
      n_tests++;
      if (cyc != 11) begin
         n_fail++;
         $display("FAIL init_restart_latency: got %0d cycles, expected 11", cyc);
      end
      for (int e = 10; e >= 0; e--) begin
         n_tests++;
         if (rk_valid !== 1'b1 || round !== e[3:0] || roundkey !== exp_rk[e] ||
             (e == 10 && roundkey !== ZERO_R10) || (e == 0 && roundkey !== 128'h0)) begin
            n_fail++;
            $display("FAIL zero_r%0d: valid=%b round=%0d key=%h, expected 1/%0d/%h",
                     e, rk_valid, round, roundkey, e, exp_rk[e]);
         end
         @(negedge clk);
      end
      n_tests++;
      if (ready !== 1'b1 || cached !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_done: ready=%b cached=%b, expected 1/1", ready, cached);
      end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_fips();
      test_restart();
      test_backpressure();
      test_random_ready();
      test_init_during_emit();
      test_reset_mid_expand();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
